wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Shares the single register-file write port (we/rd_add/rd_data) between two writeback
//  requesters: EX (ALU results) and MEM (load data). Registered output stage drives the
//  regfile write port directly. Fixed priority to MEM with an age counter that
//  guarantees EX forward progress. Writes to x0 are accepted but never reach the port.
// PARAMETERS
//  XLEN      32  data width of write data
//  MAX_WAIT  3   cycles EX may be refused while valid before it gets forced priority (>=1)
//  WAIT_W    $clog2(MAX_WAIT+1)  width of age counter (derived, not overridden)
// PORTS
//  clk_i          in   1     clock, rising edge
//  rst_i          in   1     synchronous reset, active-high
//  flush_i        in   1     drop all offers this cycle, cancel pending output write
//  ex_valid_i     in   1     EX offers a write
//  ex_ready_o     out  1     EX offer accepted this cycle
//  ex_rd_add_i    in   5     EX destination register
//  ex_rd_data_i   in   XLEN  EX write data
//  mem_valid_i    in   1     MEM offers a write
//  mem_ready_o    out  1     MEM offer accepted this cycle
//  mem_rd_add_i   in   5     MEM destination register
//  mem_rd_data_i  in   XLEN  MEM write data
//  we_o           out  1     regfile write enable (registered)
//  rd_add_o       out  5     regfile write address (registered)
//  rd_data_o      out  XLEN  regfile write data (registered)
//  ex_starved_o   out  1     age counter reached MAX_WAIT (EX forced this cycle)
// BEHAVIOUR
//  Reset: we_o=0, rd_add_o=0, rd_data_o=0, age counter=0; ready outputs 0 during rst_i.
//  Handshake: transfer when valid_i & ready_o at a rising edge. ready_o is combinational
//   from valids, age and flush_i; never depends on its own ready. Requester holds
//   valid/add/data stable until accepted.
//  Grant (per cycle, at most one):
//   - flush_i=1 or rst_i=1: no grant.
//   - ex_starved_o = (age==MAX_WAIT) & ex_valid_i -> grant EX.
//   - else mem_valid_i -> grant MEM; else ex_valid_i -> grant EX.
//  Age counter: +1 (saturating at MAX_WAIT) when ex_valid_i & !ex_ready_o & !flush_i;
//   cleared to 0 on EX grant, when ex_valid_i=0, or on flush_i.
//  Output stage, at edge ending a grant cycle: we_o <= (granted rd_add != 0),
//   rd_add_o/rd_data_o <= granted add/data. No grant: we_o <= 0, add/data hold value.
//  Latency: offer accepted in cycle N -> we_o=1 in N+1 -> value readable from regfile in
//   N+2. Full throughput: one write per cycle sustained.
//  x0: rd_add=0 offers are granted (consume their slot) but produce we_o=0.
//  Same rd from both sides: ordered by grant order; later grant wins in the regfile.
//  flush_i: refuses both offers, clears age, forces we_o<=0 at that edge (write granted
//   in the previous cycle and already presented on we_o still completes this cycle).
//  Reset mid-operation dominates flush_i and any grant; pending output write is lost.
// TESTING
//  1 Reset: assert rst_i 2 cycles with both valid -> readies 0, we_o=0, rd_add_o=0.
//  2 Single EX: ex_valid, rd=5, data=0xDEADBEEF, cycle N -> ex_ready=1 at N,
//    we_o=1/rd_add_o=5/rd_data_o=0xDEADBEEF at N+1; regfile rs1=5 reads it at N+2.
//  3 Conflict: both valid every cycle, MAX_WAIT=3 -> MEM granted 3 cycles,
//    ex_starved_o=1 and EX granted 4th, then MEM again; pattern repeats.
//  4 x0: MEM offer rd=0 data=0x1 -> mem_ready=1, we_o stays 0; EX rd=0 likewise.
//  5 Flush: both valid, flush_i=1 for one cycle -> no ready, age=0, we_o=0 next cycle;
//    offers accepted normally after flush drops.
//  6 Back-to-back MEM, rd 1..8 with distinct data -> 8 consecutive we_o pulses, correct
//    add/data, no bubbles; compare against scoreboard model of regfile.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the regfile write port between EX and MEM, MEM first with an EX age guard
module wb_write_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [4:0]      ex_rd_add_i,
  input  logic [XLEN-1:0] ex_rd_data_i,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [4:0]      mem_rd_add_i,
  input  logic [XLEN-1:0] mem_rd_data_i,
  output logic            we_o,
  output logic [4:0]      rd_add_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            ex_starved_o
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_AGE = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] age_q, age_d;
  logic              we_q, we_d;
  logic [4:0]        add_q, add_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              blk, gnt_ex, gnt_mem;
  always_comb begin
    blk          = rst_i | flush_i;
    ex_starved_o = (age_q == MAX_AGE) & ex_valid_i;
    gnt_ex       = !blk & ex_valid_i & (ex_starved_o | !mem_valid_i);
    gnt_mem      = !blk & mem_valid_i & !ex_starved_o;
    age_d        = (flush_i | !ex_valid_i | gnt_ex) ? '0 : (age_q == MAX_AGE) ? age_q : age_q + 1'b1;
    we_d         = gnt_ex ? (ex_rd_add_i != '0) : gnt_mem ? (mem_rd_add_i != '0) : 1'b0;
    add_d        = gnt_ex ? ex_rd_add_i : gnt_mem ? mem_rd_add_i : add_q;
    data_d       = gnt_ex ? ex_rd_data_i : gnt_mem ? mem_rd_data_i : data_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      age_q  <= '0;
      we_q   <= 1'b0;
      add_q  <= '0;
      data_q <= '0;
    end else begin
      age_q  <= age_d;
      we_q   <= we_d;
      add_q  <= add_d;
      data_q <= data_d;
    end
  end
  assign ex_ready_o  = gnt_ex;
  assign mem_ready_o = gnt_mem;
  assign we_o        = we_q;
  assign rd_add_o    = add_q;
  assign rd_data_o   = data_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed vectors; expected writes queued by the driver, checked by a we_o monitor
module tb_wb_write_arbiter;
  logic        clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
  logic        ex_valid_i = 1'b0, mem_valid_i = 1'b0;
  logic [4:0]  ex_rd_add_i = '0, mem_rd_add_i = '0;
  logic [31:0] ex_rd_data_i = '0, mem_rd_data_i = '0;
  logic        ex_ready_o, mem_ready_o, we_o, ex_starved_o;
  logic [4:0]  rd_add_o;
  logic [31:0] rd_data_o;
  typedef struct {logic [4:0] a; logic [31:0] d; int c;} wr_t;
  wr_t         q[$];
  logic [31:0] rf[32];
  logic [31:0] exp_rf[32];
  int          cyc = 0, n_vec = 0, n_bad = 0;
  wb_write_arbiter #(.XLEN(32), .MAX_WAIT(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_rd_add_i(ex_rd_add_i), .ex_rd_data_i(ex_rd_data_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_rd_add_i(mem_rd_add_i), .mem_rd_data_i(mem_rd_data_i),
    .we_o(we_o), .rd_add_o(rd_add_o), .rd_data_o(rd_data_o), .ex_starved_o(ex_starved_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  // bench-side regfile fed by the DUT write port
  always @(posedge clk_i) begin
    if (rst_i) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (we_o) rf[rd_add_o] <= rd_data_o;
  end
  always @(negedge clk_i) begin
    wr_t e;
    while (q.size() > 0 && q[0].c < cyc) begin
      n_vec++; n_bad++;
      $display("FAIL missing_write: no we_o in cycle %0d, required add=%0d data=%h", q[0].c, q[0].a, q[0].d);
      void'(q.pop_front());
    end
    if (we_o) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got add=%0d data=%h in cycle %0d, required none", rd_add_o, rd_data_o, cyc);
      end else begin
        e = q.pop_front();
        if (e.a !== rd_add_o || e.d !== rd_data_o || e.c != cyc) begin
          n_bad++;
          $display("FAIL write: got add=%0d data=%h cycle %0d, required add=%0d data=%h cycle %0d",
                   rd_add_o, rd_data_o, cyc, e.a, e.d, e.c);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  task automatic push(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) begin
      q.push_back('{a: a, d: d, c: cyc + 1});
      exp_rf[a] = d;
    end
  endtask
  task automatic apply(input logic r, f, ev, input logic [4:0] ea, input logic [31:0] ed,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic eer, emr, es);
    @(posedge clk_i);
    #1;
    rst_i = r; flush_i = f;
    ex_valid_i = ev; ex_rd_add_i = ea; ex_rd_data_i = ed;
    mem_valid_i = mv; mem_rd_add_i = ma; mem_rd_data_i = md;
    @(negedge clk_i);
    chk("ex_ready", {31'd0, ex_ready_o}, {31'd0, eer});
    chk("mem_ready", {31'd0, mem_ready_o}, {31'd0, emr});
    chk("ex_starved", {31'd0, ex_starved_o}, {31'd0, es});
    if (eer) push(ea, ed);
    if (emr) push(ma, md);
  endtask
  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    // reset with both requesters offering
    apply(1, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 0);
    apply(1, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 0);
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_add", {27'd0, rd_add_o}, 32'd0);
    chk("rst_data", rd_data_o, 32'd0);
    // single EX write, readable from regfile two cycles later
    apply(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0);
    idle();
    idle();
    chk("rf_x5", rf[5], 32'hDEADBEEF);
    // conflict: MEM x3, EX forced, MEM x3, EX forced
    apply(0, 0, 1, 5'd10, 32'h1000_000A, 1, 5'd11, 32'h0B00_0001, 0, 1, 0);
    apply(0, 0, 1, 5'd10, 32'h1000_000A, 1, 5'd11, 32'h0B00_0002, 0, 1, 0);
    apply(0, 0, 1, 5'd10, 32'h1000_000A, 1, 5'd11, 32'h0B00_0003, 0, 1, 0);
    apply(0, 0, 1, 5'd10, 32'h1000_000A, 1, 5'd11, 32'h0B00_0004, 1, 0, 1);
    apply(0, 0, 1, 5'd10, 32'h2000_000A, 1, 5'd11, 32'h0B00_0004, 0, 1, 0);
    apply(0, 0, 1, 5'd10, 32'h2000_000A, 1, 5'd11, 32'h0B00_0005, 0, 1, 0);
    apply(0, 0, 1, 5'd10, 32'h2000_000A, 1, 5'd11, 32'h0B00_0006, 0, 1, 0);
    apply(0, 0, 1, 5'd10, 32'h2000_000A, 1, 5'd11, 32'h0B00_0007, 1, 0, 1);
    idle();
    // x0 offers consume a grant but never write
    apply(0, 0, 0, 0, 0, 1, 5'd0, 32'h1, 0, 1, 0);
    apply(0, 0, 1, 5'd0, 32'h2, 0, 0, 0, 1, 0, 0);
    chk("x0_mem_we", {31'd0, we_o}, 32'd0);
    idle();
    chk("x0_ex_we", {31'd0, we_o}, 32'd0);
    // flush clears age; MEM write already on the port still lands
    apply(0, 0, 1, 5'd12, 32'h0C0C_0C0C, 1, 5'd13, 32'h0D00_0001, 0, 1, 0);
    apply(0, 0, 1, 5'd12, 32'h0C0C_0C0C, 1, 5'd13, 32'h0D00_0002, 0, 1, 0);
    apply(0, 1, 1, 5'd12, 32'h0C0C_0C0C, 1, 5'd13, 32'h0D00_0003, 0, 0, 0);
    apply(0, 0, 1, 5'd12, 32'h0C0C_0C0C, 1, 5'd13, 32'h0D00_0003, 0, 1, 0);
    chk("flush_we", {31'd0, we_o}, 32'd0);
    apply(0, 0, 1, 5'd12, 32'h0C0C_0C0C, 1, 5'd13, 32'h0D00_0004, 0, 1, 0);
    apply(0, 0, 1, 5'd12, 32'h0C0C_0C0C, 1, 5'd13, 32'h0D00_0005, 0, 1, 0);
    apply(0, 0, 1, 5'd12, 32'h0C0C_0C0C, 1, 5'd13, 32'h0D00_0006, 1, 0, 1);
    // back-to-back MEM to x1..x8
    for (int i = 1; i <= 8; i++)
      apply(0, 0, 0, 0, 0, 1, 5'(i), 32'hA5A5_0000 + 32'(i * 17), 0, 1, 0);
    idle();
    idle();
    for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), rf[i], exp_rf[i]);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
